// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority pick function for the round-robin arbiter.
// Sized for the largest supported requester count so one function serves every N_REQ.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int unsigned MAX_REQ   = 64;
  localparam int unsigned MAX_SEL_W = $clog2(MAX_REQ);

  typedef struct packed {
    logic                 found;
    logic [MAX_SEL_W-1:0] idx;
  } pick_t;

  // First set bit of req at or after ptr, wrapping modulo n (n a power of 2, n <= MAX_REQ).
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                    input logic [MAX_SEL_W-1:0] ptr,
                                    input int unsigned          n);
    pick_t                r;
    logic [MAX_SEL_W-1:0] idx;
    r.found = 1'b0;
    r.idx   = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = MAX_SEL_W'((32'(ptr) + i) % n);
      if (i < n && !r.found && req[idx]) begin
        r.found = 1'b1;
        r.idx   = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/nbit_mux.sv
// 1-bit N-input multiplexer; routes X_in[Select] to Y_out.
module nbit_mux #(
  parameter int unsigned DATA_IN = 8
) (
  input  logic [DATA_IN-1:0]         X_in,
  input  logic [$clog2(DATA_IN)-1:0] Select,
  output logic                       Y_out
);

  assign Y_out = X_in[Select];

endmodule

// File: rtl/nbit_rr_arbiter.sv
// Round-robin arbiter sharing one serial channel among N_REQ requesters, with bounded
// bursts per grant and a one-cycle IDLE bubble between grants.
module nbit_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           data_in,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic                       out_data,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   select,
  output logic                       busy
);

  localparam int unsigned SEL_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   grant_nxt;
  logic [SEL_W-1:0]   select_nxt;
  logic [SEL_W-1:0]   ptr, ptr_nxt;
  logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
  pick_t              pick;

  assign pick = rr_pick(MAX_REQ'(req), MAX_SEL_W'(ptr), N_REQ);

  // No out_ready term here: valid depends only on the registered select and the request.
  assign busy      = (state == GRANT);
  assign out_valid = busy && req[select];

  nbit_mux #(
    .DATA_IN (N_REQ)
  ) u_mux (
    .X_in   (data_in),
    .Select (select),
    .Y_out  (out_data)
  );

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    select_nxt = select;
    ptr_nxt    = ptr;
    cnt_nxt    = beat_cnt;
    case (state)
      IDLE: begin
        if (pick.found) begin
          state_nxt             = GRANT;
          select_nxt            = SEL_W'(pick.idx);
          grant_nxt             = '0;
          grant_nxt[SEL_W'(pick.idx)] = 1'b1;
          cnt_nxt               = '0;
        end
      end
      GRANT: begin
        // A withdrawn request releases without counting a beat; last owner drops to lowest priority.
        if (!req[select] || (out_ready && beat_cnt == CNT_W'(MAX_BURST - 1))) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = select + SEL_W'(1);
          cnt_nxt   = '0;
        end else if (out_ready) begin
          cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      select   <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      select   <= select_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

endmodule
